// File: rtl/subtrator_serial.sv
// Bit-serial a - b - bin, LSB first; done pulses WIDTH edges after the accepting edge.
// No backpressure: start is ignored while busy, and results hold until the next completion.
module subtrator_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] r_sr_q, r_sr_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    logic             ai, bi, diff, c_next;
    logic [WIDTH-1:0] r_next;

    // Single full-subtractor cell.
    always_comb begin
        ai     = a_sr_q[0];
        bi     = b_sr_q[0];
        diff   = ai ^ bi ^ c_q;
        c_next = (~ai & bi) | (~(ai ^ bi) & c_q);
        r_next = {diff, r_sr_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        r_sr_d  = r_sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        bout_d  = bout_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    c_d     = bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                r_sr_d = r_next;
                c_d    = c_next;
                cnt_d  = cnt_q + CW'(1);
                // Outputs are published in one shot so they are never seen half-updated.
                if (cnt_q == LAST_BIT) begin
                    d_d     = r_next;
                    bout_d  = c_next;
                    zero_d  = (r_next == '0);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            r_sr_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            r_sr_q  <= r_sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign d    = d_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Scoreboard bench for subtrator_serial: directed operations push expected results,
// a negedge monitor pops and checks value and completion cycle on every done pulse.
module tb_subtrator_serial;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             zero;

    subtrator_serial #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .zero  (zero)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             zero;
        int               cyc;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (expq.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("d", int'(d), int'(e.d));
                check("bout", int'(bout), int'(e.bout));
                check("zero", int'(zero), int'(e.zero));
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Called at a negedge: the next posedge is the accepting edge.
    task automatic push_exp(input logic [WIDTH-1:0] ed, input logic eb, input logic ez);
        exp_t e;
        e.d    = ed;
        e.bout = eb;
        e.zero = ez;
        e.cyc  = cyc + 1 + WIDTH;
        expq.push_back(e);
    endtask

    task automatic op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ibin,
                      input logic [WIDTH-1:0] ed, input logic eb, input logic ez);
        @(negedge clk);
        start = 1'b1;
        a     = ia;
        b     = ib;
        bin   = ibin;
        push_exp(ed, eb, ez);
        @(negedge clk);
        start = 1'b0;
        a     = ~ia;
        b     = ~ib;
        bin   = ~ibin;
        repeat (WIDTH + 1) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_d", int'(d), 0);
        check("rst_bout", int'(bout), 0);
        check("rst_zero", int'(zero), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 9 - 3: also watch busy for exactly WIDTH cycles.
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
        push_exp(4'd6, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            start = 1'b0;
            check("busy_run", int'(busy), 1);
            check("d_hold_run", int'(d), 0);
        end
        repeat (2) @(negedge clk);

        op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0);
        op(4'd5, 4'd5, 1'b0, 4'h0, 1'b0, 1'b1);
        op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
        op(4'd15, 4'd15, 1'b1, 4'hF, 1'b1, 1'b0);
        op(4'd8, 4'd7, 1'b1, 4'h0, 1'b0, 1'b1);

        // start during RUN is ignored.
        @(negedge clk);
        start = 1'b1; a = 4'd12; b = 4'd4; bin = 1'b0;
        push_exp(4'd8, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd1; b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
        check("no_restart_busy", int'(busy), 0);
        check("no_restart_d", int'(d), 8);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; a = 4'd7; b = 4'd2; bin = 1'b0;
        push_exp(4'd5, 1'b0, 1'b0);
        repeat (WIDTH + 1) @(negedge clk);
        check("b2b_done_cycle", int'(done), 1);
        a = 4'd2; b = 4'd7;
        push_exp(4'hB, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", int'(busy), 1);
        repeat (WIDTH + 1) @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        start = 1'b1; a = 4'd15; b = 4'd1; bin = 1'b0;
        push_exp(4'd14, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        void'(expq.pop_back());
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_d", int'(d), 0);
        check("abort_bout", int'(bout), 0);
        check("abort_zero", int'(zero), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 2) @(negedge clk);
        check("abort_no_done_busy", int'(busy), 0);
        op(4'd15, 4'd1, 1'b0, 4'd14, 1'b0, 1'b0);
        op(4'd1, 4'd2, 1'b0, 4'hF, 1'b1, 1'b0);

        for (int i = 0; i < 50 && expq.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
